// File: rtl/keypad_entry_pkg.sv
// keypad_pkg: shared constants, debounce state enum and key map
// for the keypad entry path.
package keypad_pkg;

    localparam logic [3:0] KEY_ENTER = 4'hE;
    localparam logic [3:0] KEY_CLEAR = 4'hC;
    localparam int         ACC_MAX   = 1023;
    localparam int         ACC_W     = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS_DB,
        ST_HELD,
        ST_REL_DB
    } db_state_e;

    // col 0 is the leftmost column, row 0 the top row
    function automatic logic [3:0] key_map(
        input logic [1:0] col,
        input logic [1:0] row
    );
        logic [3:0] code;
        unique case ({row, col})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'h0;
            4'b11_01: code = 4'hF;
            4'b11_10: code = 4'hE;
            4'b11_11: code = 4'hD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_entry_if.sv
// keypad_entry_if: keypad matrix lines plus accumulator/commit outputs.
// master = keypad_entry side, slave = keypad/consumer side.
interface keypad_entry_if;
    import keypad_pkg::*;

    logic [3:0]       ROW;
    logic [3:0]       COL;
    logic [ACC_W-1:0] ACC;
    logic [ACC_W-1:0] DOUT;
    logic             VALID;
    logic [3:0]       KEY;
    logic             KEY_STB;

    modport master (
        input  ROW,
        output COL, ACC, DOUT, VALID, KEY, KEY_STB
    );

    modport slave (
        output ROW,
        input  COL, ACC, DOUT, VALID, KEY, KEY_STB
    );

endinterface

// File: rtl/keypad_entry_scan.sv
// keypad_scan: row sync, column scan, scan classification and debounce.
// Ports: clk, rst, row (active-low), col (one-hot-low), key_code, key_stb.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int DB_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_stb
);

    localparam int TW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DB_SCANS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DB_SCANS);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    db_state_e   state_q, state_d;
    logic [3:0]  sync1_q, sync1_d;
    logic [3:0]  sync2_q, sync2_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [1:0]  col_idx_q, col_idx_d;
    logic [3:0]  col_q, col_d;
    logic [15:0] scan_q, scan_d;
    logic [3:0]  cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]  key_q, key_d;
    logic        key_stb_q, key_stb_d;

    logic        tick_end;
    logic        scan_done;
    logic [15:0] scan_full;
    logic [4:0]  hit_n;
    logic [3:0]  hit_idx;
    logic        single;
    logic        match;
    logic [3:0]  scan_code;

    // Matrix bit index is col*4+row; the slot being sampled now is
    // merged in so the last column counts toward this scan's result.
    always_comb begin
        scan_full = scan_q;
        scan_full[{col_idx_q, 2'b00} +: 4] = ~sync2_q;
        hit_n   = '0;
        hit_idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (scan_full[i]) begin
                hit_n   = hit_n + 5'd1;
                hit_idx = 4'(i);
            end
        end
    end

    assign tick_end  = (tick_q == TICK_LAST);
    assign scan_done = tick_end && (col_idx_q == 2'd3);
    assign single    = (hit_n == 5'd1);
    assign scan_code = key_map(hit_idx[3:2], hit_idx[1:0]);
    assign match     = single && (scan_code == cand_q);

    always_comb begin
        state_d   = state_q;
        sync1_d   = row;
        sync2_d   = sync1_q;
        tick_d    = tick_end ? '0 : tick_q + TW'(1);
        col_idx_d = col_idx_q;
        col_d     = col_q;
        scan_d    = scan_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        key_d     = key_q;
        key_stb_d = 1'b0;

        if (tick_end) begin
            scan_d    = scan_full;
            col_idx_d = col_idx_q + 2'd1;
            col_d     = {col_q[2:0], col_q[3]};
        end

        // MULTI has hit_n > 1, so it falls through as "not single".
        if (scan_done) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (single) begin
                        cand_d = scan_code;
                        cnt_d  = CNT_ONE;
                        if (CNT_LAST == CNT_ONE) begin
                            state_d   = ST_HELD;
                            key_d     = scan_code;
                            key_stb_d = 1'b1;
                        end else begin
                            state_d = ST_PRESS_DB;
                        end
                    end
                end
                ST_PRESS_DB: begin
                    if (match) begin
                        cnt_d = cnt_q + CNT_ONE;
                        if (cnt_q + CNT_ONE == CNT_LAST) begin
                            state_d   = ST_HELD;
                            key_d     = cand_q;
                            key_stb_d = 1'b1;
                        end
                    end else if (single) begin
                        cand_d = scan_code;
                        cnt_d  = CNT_ONE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_HELD: begin
                    if (!match) begin
                        cnt_d = CNT_ONE;
                        if (CNT_LAST == CNT_ONE) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_REL_DB;
                        end
                    end
                end
                ST_REL_DB: begin
                    if (match) begin
                        state_d = ST_HELD;
                    end else if (cnt_q + CNT_ONE == CNT_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sync1_q   <= 4'hF;
            sync2_q   <= 4'hF;
            tick_q    <= '0;
            col_idx_q <= '0;
            col_q     <= 4'b1110;
            scan_q    <= '0;
            cand_q    <= '0;
            cnt_q     <= '0;
            key_q     <= '0;
            key_stb_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            tick_q    <= tick_d;
            col_idx_q <= col_idx_d;
            col_q     <= col_d;
            scan_q    <= scan_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            key_q     <= key_d;
            key_stb_q <= key_stb_d;
        end
    end

    assign col      = col_q;
    assign key_code = key_q;
    assign key_stb  = key_stb_q;

endmodule

// File: rtl/keypad_entry.sv
// keypad_entry: decimal keypad entry into a 10-bit accumulator with
// Enter commit. Ports: CLK, RST (async high), bus (keypad_entry_if.master).
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int DB_SCANS = 4
) (
    input logic           CLK,
    input logic           RST,
    keypad_entry_if.master bus
);

    logic [3:0]       key_code;
    logic             key_stb;
    logic [3:0]       col;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic [13:0]      acc_next;

    keypad_scan #(
        .SCAN_DIV (SCAN_DIV),
        .DB_SCANS (DB_SCANS)
    ) u_scan (
        .clk      (CLK),
        .rst      (RST),
        .row      (bus.ROW),
        .col      (col),
        .key_code (key_code),
        .key_stb  (key_stb)
    );

    // 14 bits hold 1023*10+9 without wrap, so the range test is exact.
    assign acc_next = {4'd0, acc_q} * 14'd10 + {10'd0, key_code};

    always_comb begin
        acc_d   = acc_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        if (key_stb) begin
            unique case (1'b1)
                (key_code <= 4'd9): begin
                    if (acc_next <= 14'(ACC_MAX)) begin
                        acc_d = acc_next[ACC_W-1:0];
                    end
                end
                (key_code == KEY_CLEAR): begin
                    acc_d = '0;
                end
                (key_code == KEY_ENTER): begin
                    dout_d  = acc_q;
                    valid_d = 1'b1;
                    acc_d   = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
        end
    end

    assign bus.COL     = col;
    assign bus.ACC     = acc_q;
    assign bus.DOUT    = dout_q;
    assign bus.VALID   = valid_q;
    assign bus.KEY     = key_code;
    assign bus.KEY_STB = key_stb;

endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry: keypad matrix model, key-level reference model,
// directed and random key sequences for keypad_entry.
module tb_keypad_entry;

    logic clk = 1'b0;
    logic rst = 1'b1;

    keypad_entry_if bus();

    keypad_entry #(
        .SCAN_DIV (4),
        .DB_SCANS (2)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // [row][col]
    logic [3:0] kmap [0:3][0:3] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'h0, 4'hF, 4'hE, 4'hD}
    };

    logic [15:0] pressed = '0;

    always_comb begin
        bus.ROW = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (!bus.COL[c] && pressed[c*4+r]) bus.ROW[r] = 1'b0;
            end
        end
    end

    int checks = 0;
    int errors = 0;
    int stb_cnt = 0, valid_cnt = 0, stb_dbl = 0, valid_dbl = 0;
    int exp_stb = 0, exp_valid = 0;
    int m_acc = 0, m_dout = 0, m_key = 0;
    logic stb_prev = 1'b0, valid_prev = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.KEY_STB) begin
                stb_cnt++;
                if (stb_prev) stb_dbl++;
            end
            if (bus.VALID) begin
                valid_cnt++;
                if (valid_prev) valid_dbl++;
            end
        end
        stb_prev   = bus.KEY_STB;
        valid_prev = bus.VALID;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] key_mask(input logic [3:0] code);
        logic [15:0] m;
        m = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (kmap[r][c] == code) m[c*4+r] = 1'b1;
            end
        end
        return m;
    endfunction

    task automatic model_key(input logic [3:0] code);
        int nxt;
        exp_stb++;
        m_key = code;
        if (code <= 4'd9) begin
            nxt = m_acc * 10 + int'(code);
            if (nxt <= 1023) m_acc = nxt;
        end else if (code == 4'hC) begin
            m_acc = 0;
        end else if (code == 4'hE) begin
            m_dout = m_acc;
            m_acc  = 0;
            exp_valid++;
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    // Returns at the negedge just after COL wraps 0111 -> 1110.
    task automatic next_scan();
        logic [3:0] prev;
        bit seen;
        seen = 1'b0;
        prev = bus.COL;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            if (bus.COL == 4'b1110 && prev == 4'b0111) seen = 1'b1;
            prev = bus.COL;
        end
        if (!seen) check("scan_timeout", 0, 1);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_key"}, int'(bus.KEY), m_key);
        check({tag, "_stbs"}, stb_cnt, exp_stb);
        check({tag, "_valids"}, valid_cnt, exp_valid);
        check({tag, "_acc"}, int'(bus.ACC), m_acc);
        check({tag, "_dout"}, int'(bus.DOUT), m_dout);
    endtask

    task automatic press_key(input logic [3:0] code,
                             input int hold, input int rel);
        next_scan();
        pressed = key_mask(code);
        repeat (hold) next_scan();
        pressed = '0;
        repeat (rel) next_scan();
        settle();
        model_key(code);
        check_state($sformatf("key%h", code));
    endtask

    initial begin
        logic [3:0] code;

        repeat (3) @(negedge clk);
        #1;
        check("rst_col", int'(bus.COL), 4'b1110);
        check("rst_acc", int'(bus.ACC), 0);
        check("rst_dout", int'(bus.DOUT), 0);
        check("rst_valid", int'(bus.VALID), 0);
        check("rst_key", int'(bus.KEY), 0);
        check("rst_stb", int'(bus.KEY_STB), 0);
        @(negedge clk);
        rst = 1'b0;

        // digit entry: 1 2 3 E
        press_key(4'h1, 3, 3);
        press_key(4'h2, 3, 3);
        press_key(4'h3, 3, 3);
        press_key(4'hE, 3, 3);

        // overflow drop: 1 0 2 3 5 E
        press_key(4'h1, 3, 3);
        press_key(4'h0, 3, 3);
        press_key(4'h2, 3, 3);
        press_key(4'h3, 3, 3);
        press_key(4'h5, 3, 3);
        press_key(4'hE, 3, 3);

        // clear: 5 6 C
        press_key(4'h5, 3, 3);
        press_key(4'h6, 3, 3);
        press_key(4'hC, 3, 3);

        // bounce: 7 chatters each scan, then held steady
        for (int i = 0; i < 6; i++) begin
            next_scan();
            pressed = (i % 2 == 0) ? key_mask(4'h7) : '0;
        end
        next_scan();
        pressed = key_mask(4'h7);
        next_scan();
        next_scan();
        check("bounce_stb_at", int'(bus.KEY_STB), 1);
        check("bounce_key_at", int'(bus.KEY), 7);
        model_key(4'h7);
        repeat (20) next_scan();
        settle();
        check_state("bounce_hold");
        pressed = '0;
        repeat (3) next_scan();

        // multi-key: 4 and 8 together, then only 4
        next_scan();
        pressed = key_mask(4'h4) | key_mask(4'h8);
        repeat (4) next_scan();
        settle();
        check("multi_stbs", stb_cnt, exp_stb);
        next_scan();
        pressed = key_mask(4'h4);
        next_scan();
        next_scan();
        check("multi_stb_at", int'(bus.KEY_STB), 1);
        check("multi_key_at", int'(bus.KEY), 4);
        model_key(4'h4);
        next_scan();
        pressed = '0;
        repeat (3) next_scan();
        settle();
        check_state("multi");

        // async reset mid-debounce with ACC = 42
        press_key(4'hC, 3, 3);
        press_key(4'h4, 3, 3);
        press_key(4'h2, 3, 3);
        next_scan();
        pressed = key_mask(4'h9);
        next_scan();
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_col", int'(bus.COL), 4'b1110);
        check("arst_acc", int'(bus.ACC), 0);
        check("arst_dout", int'(bus.DOUT), 0);
        check("arst_valid", int'(bus.VALID), 0);
        check("arst_key", int'(bus.KEY), 0);
        check("arst_stb", int'(bus.KEY_STB), 0);
        m_acc  = 0;
        m_dout = 0;
        m_key  = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        next_scan();
        next_scan();
        check("arst_stb_at", int'(bus.KEY_STB), 1);
        check("arst_key_at", int'(bus.KEY), 9);
        model_key(4'h9);
        next_scan();
        pressed = '0;
        repeat (3) next_scan();
        settle();
        check_state("arst_rel");

        // random key sequences
        repeat (24) begin
            if ($urandom_range(0, 9) < 7) code = 4'($urandom_range(0, 9));
            else code = 4'($urandom_range(0, 15));
            press_key(code, int'($urandom_range(3, 5)),
                      int'($urandom_range(3, 5)));
        end

        check("stb_back_to_back", stb_dbl, 0);
        check("valid_back_to_back", valid_dbl, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
